threshold_mean: RTL and testbench

Upstream stage of adaptive thresholding: computes the 3×3 local mean of every pixel in the grayscale image memory and writes it into the threshold memory. The binarisation stage then reads that memory. The block scans the image in raster order after a start pulse. Per pixel, it issues nine clamped neighbourhood reads, accumulates them, divides by 9, and performs one threshold-memory write. It raises `finished` when the whole frame is done. The constant offset C is not applied here; it belongs to the binarisation stage.

---
 rtl/threshold_pkg.sv | 27 ++
 rtl/window_addr_gen.sv | 53 +++++
 rtl/threshold_mean.sv | 163 ++++++++++++++++
 tb/tb_threshold_mean.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/threshold_pkg.sv
// Shared types and constants for the 3x3 local-mean stage of adaptive thresholding.
// The divide-by-9 is a reciprocal multiply; it is exact for every 9-tap sum of 8-bit pixels.
package threshold_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LAST,
        WRITE,
        DONE
    } state_e;

    localparam int NUM_TAPS   = 9;
    localparam int TAP_BITS   = 4;
    localparam int DIV9_MUL   = 7282;
    localparam int DIV9_SHIFT = 16;
    localparam int ACC_BITS   = 12;
    localparam int PROD_BITS  = 25;

    // floor(acc / 9) for acc <= 2295, the largest possible 9-pixel sum.
    function automatic logic [7:0] div9(input logic [ACC_BITS-1:0] acc);
        logic [PROD_BITS-1:0] prod;
        prod = PROD_BITS'(acc) * PROD_BITS'(DIV9_MUL);
        return prod[DIV9_SHIFT +: 8];
    endfunction

endpackage

// File: rtl/window_addr_gen.sv
// Maps (x, y, tap) to the edge-replicated 3x3 neighbourhood address.
// Taps run row-major: tap k selects (dr, dc) = (k/3 - 1, k%3 - 1).
module window_addr_gen
    import threshold_pkg::*;
#(
    parameter int WIDTH_BITS  = 8,
    parameter int HEIGHT_BITS = 8
) (
    input  logic [WIDTH_BITS-1:0]  x,
    input  logic [HEIGHT_BITS-1:0] y,
    input  logic [TAP_BITS-1:0]    tap,
    output logic [WIDTH_BITS-1:0]  col,
    output logic [HEIGHT_BITS-1:0] row
);

    logic [1:0] row_sel;
    logic [1:0] col_sel;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        row_sel = 2'd1;
        col_sel = 2'd1;
        case (tap)
            4'd0: begin row_sel = 2'd0; col_sel = 2'd0; end
            4'd1: begin row_sel = 2'd0; col_sel = 2'd1; end
            4'd2: begin row_sel = 2'd0; col_sel = 2'd2; end
            4'd3: begin row_sel = 2'd1; col_sel = 2'd0; end
            4'd4: begin row_sel = 2'd1; col_sel = 2'd1; end
            4'd5: begin row_sel = 2'd1; col_sel = 2'd2; end
            4'd6: begin row_sel = 2'd2; col_sel = 2'd0; end
            4'd7: begin row_sel = 2'd2; col_sel = 2'd1; end
            4'd8: begin row_sel = 2'd2; col_sel = 2'd2; end
            default: begin row_sel = 2'd1; col_sel = 2'd1; end
        endcase
    end

    // Clamp at the image border; the image size is a power of two, so the far edge is all ones.
    always_comb begin
        col = x;
        row = y;
        case (col_sel)
            2'd0:    col = (x == '0) ? x : x - WIDTH_BITS'(1);
            2'd2:    col = (x == '1) ? x : x + WIDTH_BITS'(1);
            default: col = x;
        endcase
        case (row_sel)
            2'd0:    row = (y == '0) ? y : y - HEIGHT_BITS'(1);
            2'd2:    row = (y == '1) ? y : y + HEIGHT_BITS'(1);
            default: row = y;
        endcase
    end

endmodule

// File: rtl/threshold_mean.sv
// Raster-scans the image, sums the 3x3 edge-replicated neighbourhood of every pixel
// and writes floor(sum / 9) into the threshold memory, one pixel per 11 cycles.
module threshold_mean
    import threshold_pkg::*;
#(
    parameter int WIDTH_BITS  = 8,
    parameter int HEIGHT_BITS = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   iStart,
    output logic [WIDTH_BITS-1:0]  oImageCol,
    output logic [HEIGHT_BITS-1:0] oImageRow,
    input  logic [7:0]             iImageData,
    output logic [WIDTH_BITS-1:0]  oThresholdCol,
    output logic [HEIGHT_BITS-1:0] oThresholdRow,
    output logic [7:0]             oThresholdData,
    output logic                   oThresholdWren,
    output logic                   finished
);

    localparam int WIDTH  = 2 ** WIDTH_BITS;
    localparam int HEIGHT = 2 ** HEIGHT_BITS;

    state_e                   state_q,    state_d;
    logic [WIDTH_BITS-1:0]    x_q,        x_d;
    logic [HEIGHT_BITS-1:0]   y_q,        y_d;
    logic [TAP_BITS-1:0]      tap_q,      tap_d;
    logic [ACC_BITS-1:0]      acc_q,      acc_d;
    logic [WIDTH_BITS-1:0]    img_col_q,  img_col_d;
    logic [HEIGHT_BITS-1:0]   img_row_q,  img_row_d;
    logic [WIDTH_BITS-1:0]    thr_col_q,  thr_col_d;
    logic [HEIGHT_BITS-1:0]   thr_row_q,  thr_row_d;
    logic [7:0]               thr_data_q, thr_data_d;
    logic                     wren_q,     wren_d;
    logic                     finished_q, finished_d;

    logic [ACC_BITS-1:0]      acc_sum;
    logic                     last_pixel;
    logic [WIDTH_BITS-1:0]    gen_col;
    logic [HEIGHT_BITS-1:0]   gen_row;

    assign acc_sum    = acc_q + ACC_BITS'(iImageData);
    assign last_pixel = (x_q == WIDTH_BITS'(WIDTH - 1)) && (y_q == HEIGHT_BITS'(HEIGHT - 1));

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        tap_d      = tap_q;
        acc_d      = acc_q;
        thr_col_d  = thr_col_q;
        thr_row_d  = thr_row_q;
        thr_data_d = thr_data_q;
        wren_d     = 1'b0;
        finished_d = finished_q;

        case (state_q)
            IDLE, DONE: begin
                if (iStart) begin
                    finished_d = 1'b0;
                    x_d        = '0;
                    y_d        = '0;
                    tap_d      = '0;
                    acc_d      = '0;
                    state_d    = READ;
                end
            end
            READ: begin
                // Data arriving now belongs to the previous tap; tap 0 sees stale data.
                if (tap_q != '0) acc_d = acc_sum;
                if (tap_q == TAP_BITS'(NUM_TAPS - 1)) begin
                    tap_d   = '0;
                    state_d = LAST;
                end else begin
                    tap_d = tap_q + TAP_BITS'(1);
                end
            end
            LAST: begin
                acc_d      = acc_sum;
                thr_col_d  = x_q;
                thr_row_d  = y_q;
                thr_data_d = div9(acc_sum);
                wren_d     = 1'b1;
                state_d    = WRITE;
            end
            WRITE: begin
                acc_d = '0;
                tap_d = '0;
                if (last_pixel) begin
                    finished_d = 1'b1;
                    state_d    = DONE;
                end else begin
                    x_d = x_q + WIDTH_BITS'(1);
                    if (x_q == '1) y_d = y_q + HEIGHT_BITS'(1);
                    state_d = READ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    window_addr_gen #(
        .WIDTH_BITS  (WIDTH_BITS),
        .HEIGHT_BITS (HEIGHT_BITS)
    ) u_addr_gen (
        .x   (x_d),
        .y   (y_d),
        .tap (tap_d),
        .col (gen_col),
        .row (gen_row)
    );

    // The read address is registered from the next-cycle position so it lines up with the tap.
    always_comb begin
        img_col_d = '0;
        img_row_d = '0;
        if (state_d == READ) begin
            img_col_d = gen_col;
            img_row_d = gen_row;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            tap_q      <= '0;
            acc_q      <= '0;
            img_col_q  <= '0;
            img_row_q  <= '0;
            thr_col_q  <= '0;
            thr_row_q  <= '0;
            thr_data_q <= '0;
            wren_q     <= 1'b0;
            finished_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            tap_q      <= tap_d;
            acc_q      <= acc_d;
            img_col_q  <= img_col_d;
            img_row_q  <= img_row_d;
            thr_col_q  <= thr_col_d;
            thr_row_q  <= thr_row_d;
            thr_data_q <= thr_data_d;
            wren_q     <= wren_d;
            finished_q <= finished_d;
        end
    end

    assign oImageCol      = img_col_q;
    assign oImageRow      = img_row_q;
    assign oThresholdCol  = thr_col_q;
    assign oThresholdRow  = thr_row_q;
    assign oThresholdData = thr_data_q;
    assign oThresholdWren = wren_q;
    assign finished       = finished_q;

endmodule

// File: tb/tb_threshold_mean.sv
// Directed bench for threshold_mean on a 4x4 image with a 1-cycle behavioural image RAM.
// Cycle n is the interval after clock edge n-1, where edge 0 samples iStart.
module tb_threshold_mean;
    import threshold_pkg::*;

    localparam int WB     = 2;
    localparam int HB     = 2;
    localparam int NPIX   = 16;
    localparam int LOGLEN = 256;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          iStart = 1'b0;
    logic [WB-1:0] oImageCol;
    logic [HB-1:0] oImageRow;
    logic [7:0]    iImageData;
    logic [WB-1:0] oThresholdCol;
    logic [HB-1:0] oThresholdRow;
    logic [7:0]    oThresholdData;
    logic          oThresholdWren;
    logic          finished;

    threshold_mean #(
        .WIDTH_BITS  (WB),
        .HEIGHT_BITS (HB)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .iStart         (iStart),
        .oImageCol      (oImageCol),
        .oImageRow      (oImageRow),
        .iImageData     (iImageData),
        .oThresholdCol  (oThresholdCol),
        .oThresholdRow  (oThresholdRow),
        .oThresholdData (oThresholdData),
        .oThresholdWren (oThresholdWren),
        .finished       (finished)
    );

    always #5 clock = ~clock;

    logic [7:0] mem [NPIX];
    always @(posedge clock) iImageData <= mem[{oImageRow, oImageCol}];

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]    exp_data [NPIX];
    logic [WB-1:0] wr_col   [32];
    logic [HB-1:0] wr_row   [32];
    logic [7:0]    wr_data  [32];
    int            wr_cyc   [32];
    int            wr_cnt;
    int            fin_cycle;
    logic [WB-1:0] col_log  [LOGLEN];
    logic [HB-1:0] row_log  [LOGLEN];
    logic          fin_log  [LOGLEN];
    logic [17:0]   out_log  [LOGLEN];

    // Start a frame and log every output for n_cyc cycles; optional mid-frame iStart pulse and reset.
    task automatic run_frame(input int n_cyc, input int pulse_cyc, input int rst_cyc);
        for (int k = 0; k < 32; k++) begin
            wr_col[k] = 'x; wr_row[k] = 'x; wr_data[k] = 'x; wr_cyc[k] = -1;
        end
        wr_cnt    = 0;
        fin_cycle = -1;
        @(negedge clock);
        iStart = 1'b1;
        @(posedge clock);
        for (int cyc = 1; cyc <= n_cyc; cyc++) begin
            @(negedge clock);
            if (cyc == 1) iStart = 1'b0;
            if (cyc == pulse_cyc) iStart = 1'b1;
            else if (cyc == pulse_cyc + 1) iStart = 1'b0;
            if (cyc == rst_cyc) reset_n = 1'b0;
            else if (cyc == rst_cyc + 1) reset_n = 1'b1;
            col_log[cyc] = oImageCol;
            row_log[cyc] = oImageRow;
            fin_log[cyc] = finished;
            out_log[cyc] = {oImageCol, oImageRow, oThresholdCol, oThresholdRow,
                            oThresholdData, oThresholdWren, finished};
            if (oThresholdWren === 1'b1) begin
                if (wr_cnt < 32) begin
                    wr_col[wr_cnt]  = oThresholdCol;
                    wr_row[wr_cnt]  = oThresholdRow;
                    wr_data[wr_cnt] = oThresholdData;
                    wr_cyc[wr_cnt]  = cyc;
                end
                wr_cnt++;
            end
            if (finished === 1'b1 && fin_cycle < 0) fin_cycle = cyc;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        n_checks++;
        if ({oImageCol, oImageRow, oThresholdCol, oThresholdRow, oThresholdData,
             oThresholdWren, finished} !== 18'd0)
            $display("FAIL reset_outputs got col=%0d row=%0d tcol=%0d trow=%0d tdata=%0d wren=%b fin=%b want all 0",
                     oImageCol, oImageRow, oThresholdCol, oThresholdRow, oThresholdData,
                     oThresholdWren, finished);
        else n_pass++;
        reset_n = 1'b1;
        @(negedge clock);
        n_checks++;
        if (oThresholdWren !== 1'b0 || finished !== 1'b0)
            $display("FAIL idle_quiet got wren=%b fin=%b want 0 0", oThresholdWren, finished);
        else n_pass++;
    endtask

    task automatic test_uniform();
        for (int k = 0; k < NPIX; k++) begin mem[k] = 8'd100; exp_data[k] = 8'd100; end
        run_frame(185, -1, -1);
        n_checks++;
        if (wr_cnt != NPIX) $display("FAIL uniform_count got %0d want %0d", wr_cnt, NPIX);
        else n_pass++;
        for (int k = 0; k < NPIX; k++) begin
            n_checks++;
            if (wr_col[k] !== WB'(k % 4) || wr_row[k] !== HB'(k / 4) ||
                wr_data[k] !== exp_data[k] || wr_cyc[k] != 11 + 11 * k)
                $display("FAIL uniform_pix%0d got col=%0d row=%0d data=%0d cyc=%0d want col=%0d row=%0d data=%0d cyc=%0d",
                         k, wr_col[k], wr_row[k], wr_data[k], wr_cyc[k], k % 4, k / 4, exp_data[k], 11 + 11 * k);
            else n_pass++;
        end
        n_checks++;
        if (fin_cycle != 177) $display("FAIL uniform_finished_cycle got %0d want 177", fin_cycle);
        else n_pass++;
        n_checks++;
        if (fin_log[185] !== 1'b1) $display("FAIL finished_held got %b want 1", fin_log[185]);
        else n_pass++;
    endtask

    task automatic test_single_pixel();
        for (int k = 0; k < NPIX; k++) begin mem[k] = 8'd0; exp_data[k] = 8'd0; end
        mem[0]      = 8'd90;
        exp_data[0] = 8'd40;
        exp_data[1] = 8'd20;
        exp_data[4] = 8'd20;
        exp_data[5] = 8'd10;
        run_frame(180, -1, -1);
        n_checks++;
        if (wr_cnt != NPIX) $display("FAIL single_count got %0d want %0d", wr_cnt, NPIX);
        else n_pass++;
        for (int k = 0; k < NPIX; k++) begin
            n_checks++;
            if (wr_col[k] !== WB'(k % 4) || wr_row[k] !== HB'(k / 4) || wr_data[k] !== exp_data[k])
                $display("FAIL single_pix%0d got col=%0d row=%0d data=%0d want col=%0d row=%0d data=%0d",
                         k, wr_col[k], wr_row[k], wr_data[k], k % 4, k / 4, exp_data[k]);
            else n_pass++;
        end
    endtask

    task automatic test_saturate();
        for (int k = 0; k < NPIX; k++) mem[k] = 8'd255;
        run_frame(180, -1, -1);
        n_checks++;
        if (wr_cnt != NPIX) $display("FAIL sat_count got %0d want %0d", wr_cnt, NPIX);
        else n_pass++;
        for (int k = 0; k < NPIX; k++) begin
            n_checks++;
            if (wr_data[k] !== 8'd255) $display("FAIL sat_pix%0d got %0d want 255", k, wr_data[k]);
            else n_pass++;
        end
    endtask

    // Pixel (3,3) is pixel 15; its taps are presented during cycles 166..174 as (row,col).
    task automatic test_tap_addr();
        logic [1:0] exp_r [9];
        logic [1:0] exp_c [9];
        exp_r = '{2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
        exp_c = '{2'd2, 2'd3, 2'd3, 2'd2, 2'd3, 2'd3, 2'd2, 2'd3, 2'd3};
        for (int k = 0; k < NPIX; k++) mem[k] = 8'(k * 7);
        run_frame(180, -1, -1);
        for (int t = 0; t < 9; t++) begin
            n_checks++;
            if (row_log[166 + t] !== exp_r[t] || col_log[166 + t] !== exp_c[t])
                $display("FAIL tap%0d_addr got (%0d,%0d) want (%0d,%0d)",
                         t, row_log[166 + t], col_log[166 + t], exp_r[t], exp_c[t]);
            else n_pass++;
        end
        n_checks++;
        if (row_log[175] !== 2'd0 || col_log[175] !== 2'd0)
            $display("FAIL addr_outside_read got (%0d,%0d) want (0,0)", row_log[175], col_log[175]);
        else n_pass++;
    endtask

    task automatic test_start_ignored_restart();
        for (int k = 0; k < NPIX; k++) begin mem[k] = 8'd100; exp_data[k] = 8'd100; end
        run_frame(180, 50, -1);
        n_checks++;
        if (wr_cnt != NPIX || wr_cyc[NPIX-1] != 176)
            $display("FAIL midframe_start got count=%0d last_cyc=%0d want count=16 last_cyc=176",
                     wr_cnt, wr_cyc[NPIX-1]);
        else n_pass++;
        run_frame(180, -1, -1);
        n_checks++;
        if (fin_log[1] !== 1'b0) $display("FAIL restart_finished_drop got %b want 0", fin_log[1]);
        else n_pass++;
        n_checks++;
        if (wr_cnt != NPIX || fin_cycle != 177)
            $display("FAIL restart_frame got count=%0d fin_cyc=%0d want count=16 fin_cyc=177", wr_cnt, fin_cycle);
        else n_pass++;
        for (int k = 0; k < NPIX; k++) begin
            n_checks++;
            if (wr_data[k] !== exp_data[k] || wr_cyc[k] != 11 + 11 * k)
                $display("FAIL restart_pix%0d got data=%0d cyc=%0d want data=%0d cyc=%0d",
                         k, wr_data[k], wr_cyc[k], exp_data[k], 11 + 11 * k);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_frame();
        int nonzero;
        for (int k = 0; k < NPIX; k++) begin mem[k] = 8'd0; exp_data[k] = 8'd0; end
        mem[0]      = 8'd90;
        exp_data[0] = 8'd40;
        exp_data[1] = 8'd20;
        exp_data[4] = 8'd20;
        exp_data[5] = 8'd10;
        run_frame(120, -1, 60);
        n_checks++;
        if (wr_cnt != 5 || wr_cyc[4] != 55)
            $display("FAIL abort_writes got count=%0d last_cyc=%0d want count=5 last_cyc=55", wr_cnt, wr_cyc[4]);
        else n_pass++;
        nonzero = 0;
        for (int c = 61; c <= 120; c++) if (out_log[c] !== 18'd0) nonzero++;
        n_checks++;
        if (nonzero != 0) $display("FAIL abort_outputs_zero got %0d nonzero cycles want 0", nonzero);
        else n_pass++;
        n_checks++;
        if (dut.state_q !== IDLE) $display("FAIL abort_state got %0d want IDLE", dut.state_q);
        else n_pass++;
        run_frame(180, -1, -1);
        n_checks++;
        if (wr_cnt != NPIX || fin_cycle != 177)
            $display("FAIL after_abort_frame got count=%0d fin_cyc=%0d want count=16 fin_cyc=177", wr_cnt, fin_cycle);
        else n_pass++;
        for (int k = 0; k < NPIX; k++) begin
            n_checks++;
            if (wr_col[k] !== WB'(k % 4) || wr_row[k] !== HB'(k / 4) || wr_data[k] !== exp_data[k])
                $display("FAIL after_abort_pix%0d got col=%0d row=%0d data=%0d want col=%0d row=%0d data=%0d",
                         k, wr_col[k], wr_row[k], wr_data[k], k % 4, k / 4, exp_data[k]);
            else n_pass++;
        end
    endtask

    initial begin
        for (int k = 0; k < NPIX; k++) mem[k] = 8'd0;
        test_reset();
        test_uniform();
        test_single_pixel();
        test_saturate();
        test_tap_addr();
        test_start_ignored_restart();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
